serial_adder_arbiter: RTL and testbench
=======================================

Name:
serial_adder_arbiter

Overview:
- Shares one 1-bit full-add cell (two half-add stages plus carry OR) between two requesters.
- Adds WIDTH-bit operands bit-serially, LSB first, over WIDTH cycles, with a registered carry.
- Arbitrates round-robin between the requesters and returns the sum, carry-out and the ID of the served requester.
- Area-saving alternative to a parallel adder where add throughput is low.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- CW, $clog2(WIDTH), bit-counter width (derived, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 add request; held until gnt0 is seen.
- a0  input  WIDTH  requester 0 operand A; stable while req0 is high.
- b0  input  WIDTH  requester 0 operand B; stable while req0 is high.
- gnt0  output  1  one-cycle pulse: requester 0 operands captured.
- req1  input  1  requester 1 add request.
- a1  input  WIDTH  requester 1 operand A.
- b1  input  WIDTH  requester 1 operand B.
- gnt1  output  1  one-cycle pulse: requester 1 operands captured.
- sum  output  WIDTH  result of the last completed add.
- cout  output  1  carry-out of the last completed add.
- done  output  1  one-cycle pulse: sum/cout/done_id updated.
- done_id  output  1  requester served by the last completed add (0/1).
- busy  output  1  high in ADD and DONE.

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low. All state is flops on posedge clk / negedge rst_n.
- Reset values: state=IDLE, gnt0=gnt1=0, sum=0, cout=0, done=0, done_id=0, busy=0, carry=0, bit counter=0, operand shift registers=0, last-grant pointer=1 (so requester 0 wins the first tie).

FSM: IDLE, ADD, DONE.
- IDLE, no req: stay in IDLE.
- IDLE, any req at edge E:
  - Select the winner. If only one requester is active, it wins. If both are active, the requester opposite to the last-grant pointer wins.
  - Load the winner's a/b into shift registers.
  - Clear carry and bit counter; update the pointer to the winner.
  - Register the winner's gnt high for exactly one cycle after E.
  - Go to ADD.
- ADD, each cycle:
  - s = a[0]^b[0]^carry; carry_next = a[0]&b[0] | carry&(a[0]^b[0]).
  - s shifts into the result register from the MSB side; operands shift right by one.
  - Counter increments.
  - After the cycle with counter = WIDTH-1, go to DONE.
- DONE, one cycle:
  - sum = result register; cout = final carry; done_id = served ID; done=1.
  - Next state is IDLE.

Timing and handshake:
- Latency: req sampled at edge 0; gnt high during cycle 1; ADD occupies cycles 1..WIDTH; done is high in cycle WIDTH+1; IDLE in cycle WIDTH+2.
- Throughput: one add per WIDTH+2 cycles.
- Requester must drop req in the cycle after it sees gnt, unless it issues a new request. A req still high in IDLE is treated as a new request.
- Requests arriving during ADD/DONE are ignored (not queued) and are evaluated in the next IDLE.
- Stable outputs: sum/cout/done_id hold their values between done pulses. They are not cleared on a new grant.
- Width: internal math is strictly WIDTH+1 bits (sum + cout). Wrap-around is exact modulo 2^WIDTH, with overflow reported in cout.
- Reset mid-operation: asserting rst_n low in any state returns all outputs to their reset values immediately (asynchronously). The in-flight add is discarded and no done is produced.
- Fairness: under continuous requests from both requesters, grants strictly alternate 0,1,0,1.

Test Plan:
- WIDTH=8, req0 only, a0=0x5A, b0=0x3C -> gnt0 in cycle 1; done in cycle 9 with sum=0x96, cout=0, done_id=0; busy high cycles 1..9.
- req1 only, a1=0xFF, b1=0x01 -> sum=0x00, cout=1, done_id=1; sum/cout held after done falls.
- After reset, req0 and req1 both held, 0x10+0x20 and 0x7F+0x80 -> first done_id=0 with sum=0x30; second done_id=1 with sum=0xFF, cout=0; gnt pulses never overlap.
- Both requesters held for 4 adds -> grant order 0,1,0,1; each done spaced exactly 10 cycles.
- Start add 0xAA+0x55, pull rst_n low in ADD cycle 4 -> all outputs 0 immediately; no done; a new request after release completes normally with sum=0xFF.
- req1 raised mid-ADD of a requester-0 add (0x00+0x00) -> ignored until IDLE; gnt1 in the cycle after IDLE is sampled; first result sum=0x00, cout=0, done_id=0.

Source files
------------

// File: rtl/serial_adder_arbiter_if.sv
// Request/response bundle for the two-requester bit-serial adder.
interface serial_adder_arbiter_if #(parameter int WIDTH = 8);
  logic             req0, req1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             gnt0, gnt1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             done;
  logic             done_id;
  logic             busy;

  modport master (output req0, a0, b0, req1, a1, b1,
                  input  gnt0, gnt1, sum, cout, done, done_id, busy);
  modport slave  (input  req0, a0, b0, req1, a1, b1,
                  output gnt0, gnt1, sum, cout, done, done_id, busy);
endinterface

// File: rtl/serial_adder_arbiter.sv
// One shared 1-bit full-add cell, time-multiplexed round-robin between two
// requesters; operands are consumed LSB first over WIDTH cycles.
module serial_adder_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_adder_arbiter_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, ptr_q, ptr_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             cout_q, cout_d, done_q, done_d, id_q, id_d;

  logic win, h1, s, c_nxt;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign win   = bus.req1 & (~bus.req0 | ~ptr_q);
  assign h1    = a_q[0] ^ b_q[0];
  assign s     = h1 ^ carry_q;
  assign c_nxt = (a_q[0] & b_q[0]) | (carry_q & h1);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    id_d    = id_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.req0 | bus.req1) begin
        a_d     = win ? bus.a1 : bus.a0;
        b_d     = win ? bus.b1 : bus.b0;
        carry_d = 1'b0;
        cnt_d   = '0;
        ptr_d   = win;
        gnt0_d  = ~win;
        gnt1_d  = win;
        state_d = ADD;
      end
      ADD: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {s, res_q[WIDTH-1:1]};
        carry_d = c_nxt;
        cnt_d   = cnt_q + CW'(1);
        // Results are registered on the final bit so they appear with done.
        if (cnt_q == LAST) begin
          sum_d   = {s, res_q[WIDTH-1:1]};
          cout_d  = c_nxt;
          id_d    = ptr_q;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ptr_q   <= 1'b1;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      id_q    <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      id_q    <= id_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done_q  <= done_d;
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.sum     = sum_q;
  assign bus.cout    = cout_q;
  assign bus.done    = done_q;
  assign bus.done_id = id_q;
  assign bus.busy    = (state_q != IDLE);
endmodule

// File: tb/tb_serial_adder_arbiter.sv
// Directed bench for serial_adder_arbiter at WIDTH=8: vector table plus
// hand-written sequences for arbitration, mid-add requests and reset.
module tb_serial_adder_arbiter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  serial_adder_arbiter_if #(.WIDTH(W)) bus ();
  serial_adder_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic         r0, r1;
    logic [W-1:0] a0, b0, a1, b1;
    logic [W-1:0] esum;
    logic         ecout;
    logic         eid;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 while idle; returns at posedge+1 of the first IDLE cycle after done.
  task automatic do_add(input vec_t v);
    int n;
    bus.req0 = v.r0; bus.a0 = v.a0; bus.b0 = v.b0;
    bus.req1 = v.r1; bus.a1 = v.a1; bus.b1 = v.b1;
    tick(); n = 1;
    chk("gnt", {30'd0, bus.gnt1, bus.gnt0}, v.eid ? 32'd2 : 32'd1);
    chk("busy_c1", bus.busy, 1);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    while (!bus.done && n < 30) begin tick(); n++; end
    chk("done_lat", n, W + 1);
    chk("busy_done", bus.busy, 1);
    chk("sum", bus.sum, v.esum);
    chk("cout", bus.cout, v.ecout);
    chk("done_id", bus.done_id, v.eid);
    tick();
    chk("done_pulse", bus.done, 0);
    chk("busy_idle", bus.busy, 0);
  endtask

  initial begin
    int n, k, ov;
    int  tdone[4];
    logic        iddone[4];
    logic [W-1:0] sdone[4];
    logic seen;

    vt[0] = '{1, 0, 8'h5A, 8'h3C, 8'h00, 8'h00, 8'h96, 0, 0};
    vt[1] = '{0, 1, 8'h00, 8'h00, 8'hFF, 8'h01, 8'h00, 1, 1};
    vt[2] = '{1, 1, 8'h10, 8'h20, 8'h7F, 8'h80, 8'h30, 0, 0};
    vt[3] = '{1, 1, 8'h10, 8'h20, 8'h7F, 8'h80, 8'hFF, 0, 1};
    vt[4] = '{1, 0, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFE, 1, 0};
    vt[5] = '{0, 1, 8'h00, 8'h00, 8'h12, 8'h34, 8'h46, 0, 1};

    bus.req0 = 0; bus.req1 = 0; bus.a0 = 0; bus.b0 = 0; bus.a1 = 0; bus.b1 = 0;
    #12;
    chk("rst_outs", {bus.gnt0, bus.gnt1, bus.cout, bus.done, bus.done_id, bus.busy}, 0);
    chk("rst_sum", bus.sum, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) do_add(vt[i]);

    // Results hold across idle cycles after done falls.
    repeat (3) tick();
    chk("hold_sum", bus.sum, 8'h46);
    chk("hold_id", bus.done_id, 1);

    // Both held continuously: strict alternation, one done per 10 cycles.
    bus.req0 = 1; bus.a0 = 8'h01; bus.b0 = 8'h02;
    bus.req1 = 1; bus.a1 = 8'h04; bus.b1 = 8'h05;
    k = 0; ov = 0;
    for (int t = 0; t < 60 && k < 4; t++) begin
      tick();
      if (bus.gnt0 && bus.gnt1) ov++;
      if (bus.done) begin
        tdone[k] = t; iddone[k] = bus.done_id; sdone[k] = bus.sum; k++;
        if (k == 4) begin bus.req0 = 0; bus.req1 = 0; end
      end
    end
    chk("fair_count", k, 4);
    chk("fair_overlap", ov, 0);
    if (k == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("fair_id", iddone[i], i % 2);
        chk("fair_sum", sdone[i], (i % 2) ? 8'h09 : 8'h03);
        if (i > 0) chk("fair_space", tdone[i] - tdone[i-1], 10);
      end
    end
    repeat (3) tick();

    // req1 raised mid-ADD is ignored until the following IDLE.
    bus.req0 = 1; bus.a0 = 8'h00; bus.b0 = 8'h00;
    tick(); n = 1;
    chk("mid_gnt0", bus.gnt0, 1);
    bus.req0 = 0;
    seen = 0;
    while (!bus.done && n < 30) begin
      if (n == 2) begin bus.req1 = 1; bus.a1 = 8'h03; bus.b1 = 8'h04; end
      tick(); n++;
      if (bus.gnt1) seen = 1;
    end
    chk("mid_lat", n, 9);
    chk("mid_nogrant", seen, 0);
    chk("mid_sum", {bus.cout, bus.sum}, 9'h000);
    chk("mid_id", bus.done_id, 0);
    tick();
    chk("mid_idle", {bus.busy, bus.gnt1}, 0);
    tick();
    chk("mid_gnt1", bus.gnt1, 1);
    bus.req1 = 0;
    n = 0;
    while (!bus.done && n < 30) begin tick(); n++; end
    chk("mid_sum2", bus.sum, 8'h07);
    chk("mid_id2", bus.done_id, 1);
    repeat (2) tick();

    // Reset during ADD clears outputs immediately and drops the add.
    bus.req0 = 1; bus.a0 = 8'hAA; bus.b0 = 8'h55;
    tick();
    bus.req0 = 0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", {bus.gnt0, bus.gnt1, bus.cout, bus.done, bus.done_id, bus.busy}, 0);
    chk("rst_mid_sum", bus.sum, 0);
    tick(); tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin tick(); if (bus.done || bus.busy) seen = 1; end
    chk("rst_nodone", seen, 0);
    vt[0] = '{1, 0, 8'hAA, 8'h55, 8'h00, 8'h00, 8'hFF, 0, 0};
    do_add(vt[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
